// File: rtl/seg595_pkg.sv
// seg595_pkg
//   Shared definitions for the 74HC595 seven-segment scanner:
//   - FONT        : 16-entry hex font, 7 bits {g,f,e,d,c,b,a}, bit = 1 means lit
//   - state_t     : scanner FSM state encoding
//   - SHIFT_TICKS : ticks spent in SHIFT (two ticks per serial bit, 16 bits)
//   - sel_byte()  : digit-select byte for a given digit index
package seg595_pkg;

  localparam int SHIFT_TICKS = 32;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LATCH_H = 3'd3,
    ST_LATCH_L = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  // One-hot select for digit 'index' when 'active', otherwise no digit.
  // dig_act_low flips the whole byte so the selected bit reads 0.
  function automatic logic [7:0] sel_byte(input logic [2:0] index,
                                          input logic       active,
                                          input logic       dig_act_low);
    logic [7:0] sel;
    sel = active ? (8'h01 << index) : 8'h00;
    return dig_act_low ? ~sel : sel;
  endfunction

endpackage

// File: rtl/seg595_font.sv
// seg595_font
//   Combinational hex-to-segment decoder. Polarity and decimal point are
//   applied by the parent.
//   code : 4-bit hex digit
//   segs : {g,f,e,d,c,b,a}, 1 = lit
module seg595_font
  import seg595_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] segs
);

  assign segs = FONT[code];

endmodule

// File: rtl/seg595_scan_gen.sv
// seg595_scan_gen
//   Multiplexed seven-segment scanner feeding two cascaded 74HC595s.
//   Each digit gets a 16-bit word {seg_byte, sel_byte}, shifted MSB first,
//   then latched with RCK. Everything advances on a one-clk tick every
//   CLK_DIV clocks; one tick is half an SCK period.
//   Ports:
//     clk, rst_n  : system clock, asynchronous active-low reset
//     dat         : 4 bits per digit, digit 0 in dat[3:0]
//     dat_en      : per-digit enable (0 = digit dark and not selected)
//     dot_en      : per-digit decimal point
//     blank       : 1 = whole frame dark
//     seg_rck     : 595 storage latch clock
//     seg_sck     : 595 shift clock
//     seg_din     : 595 serial data
//     frame_done  : one-clk pulse when the last digit's dwell ends
module seg595_scan_gen
  import seg595_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 150,
  parameter int HOLD_TICKS   = 0,
  parameter bit SEG_ACT_HIGH = 1'b1,
  parameter bit DIG_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] dat,
  input  logic [NUM_DIGITS-1:0]   dat_en,
  input  logic [NUM_DIGITS-1:0]   dot_en,
  input  logic                    blank,
  output logic                    seg_rck,
  output logic                    seg_sck,
  output logic                    seg_din,
  output logic                    frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [IDX_W-1:0]        digit_idx;
  logic [4:0]              bit_k;
  logic [7:0]              hold_cnt;
  logic [15:0]             word;

  logic [4*NUM_DIGITS-1:0] snap_dat;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic [NUM_DIGITS-1:0]   snap_dot;
  logic                    snap_blank;

  // Tick divider
  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Word build. Digit 0's LOAD takes the snapshot on the same edge that
  // builds its word, so that word is formed from the live inputs; later
  // digits read the held snapshot, keeping the whole frame coherent.
  logic                    use_live;
  logic [4*NUM_DIGITS-1:0] frame_dat;
  logic [NUM_DIGITS-1:0]   frame_en;
  logic [NUM_DIGITS-1:0]   frame_dot;
  logic                    frame_blank;
  logic [3:0]              cur_code;
  logic [6:0]              font_segs;
  logic                    digit_lit;
  logic [7:0]              seg_lit;
  logic [7:0]              seg_out;
  logic [15:0]             word_nxt;

  assign use_live    = (digit_idx == '0);
  assign frame_dat   = use_live ? dat    : snap_dat;
  assign frame_en    = use_live ? dat_en : snap_en;
  assign frame_dot   = use_live ? dot_en : snap_dot;
  assign frame_blank = use_live ? blank  : snap_blank;
  assign cur_code    = frame_dat[4*digit_idx +: 4];
  assign digit_lit   = frame_en[digit_idx] & ~frame_blank;

  seg595_font u_font (
    .code (cur_code),
    .segs (font_segs)
  );

  assign seg_lit  = digit_lit ? {frame_dot[digit_idx], font_segs} : 8'h00;
  assign seg_out  = SEG_ACT_HIGH ? seg_lit : ~seg_lit;
  assign word_nxt = {seg_out, sel_byte(3'(digit_idx), digit_lit, DIG_ACT_LOW)};

  // FSM
  logic digit_done;
  logic last_digit;

  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    digit_done = 1'b0;
    if (tick) begin
      unique case (state)
        ST_IDLE:    state_nxt = ST_LOAD;
        ST_LOAD:    state_nxt = ST_SHIFT;
        ST_SHIFT:   if (bit_k == 5'(SHIFT_TICKS - 1)) state_nxt = ST_LATCH_H;
        ST_LATCH_H: state_nxt = ST_LATCH_L;
        ST_LATCH_L: begin
          if (HOLD_TICKS == 0) begin
            state_nxt  = ST_LOAD;
            digit_done = 1'b1;
          end else begin
            state_nxt  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 8'(HOLD_TICKS - 1)) begin
            state_nxt  = ST_LOAD;
            digit_done = 1'b1;
          end
        end
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath and pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_rck    <= 1'b0;
      seg_sck    <= 1'b0;
      seg_din    <= 1'b0;
      frame_done <= 1'b0;
      digit_idx  <= '0;
      bit_k      <= '0;
      hold_cnt   <= '0;
      word       <= '0;
      snap_dat   <= '0;
      snap_en    <= '0;
      snap_dot   <= '0;
      snap_blank <= 1'b0;
    end else begin
      frame_done <= digit_done & last_digit;
      if (tick) begin
        unique case (state)
          ST_LOAD: begin
            word  <= word_nxt;
            bit_k <= '0;
            if (use_live) begin
              snap_dat   <= dat;
              snap_en    <= dat_en;
              snap_dot   <= dot_en;
              snap_blank <= blank;
            end
          end
          ST_SHIFT: begin
            bit_k <= bit_k + 1'b1;
            // Even k: drop SCK and present the next bit (15 - k/2 == ~k[4:1]);
            // odd k: raise SCK with data held a full tick.
            if (!bit_k[0]) begin
              seg_sck <= 1'b0;
              seg_din <= word[~bit_k[4:1]];
            end else begin
              seg_sck <= 1'b1;
            end
          end
          ST_LATCH_H: seg_rck <= 1'b1;
          ST_LATCH_L: begin
            seg_rck  <= 1'b0;
            hold_cnt <= '0;
          end
          ST_HOLD:    hold_cnt <= hold_cnt + 1'b1;
          default: ;
        endcase
        if (digit_done) digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg595_scan_gen.sv
// tb_seg595_scan_gen
//   Two scanner instances with different parameter sets share one clock.
//   A monitor rebuilds every shifted word from SCK/DIN and compares it,
//   together with the timing of SCK, RCK and frame_done, against words
//   derived from the display inputs held at the start of each frame.
module tb_seg595_scan_gen;

  localparam int A_N = 8, A_CD = 4, A_H = 0;
  localparam int B_N = 3, B_CD = 3, B_H = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] in_dat [2];
  logic [7:0]  in_en  [2];
  logic [7:0]  in_dot [2];
  logic        in_blank [2];

  logic rck_a, sck_a, din_a, fd_a;
  logic rck_b, sck_b, din_b, fd_b;

  seg595_scan_gen #(
    .NUM_DIGITS(A_N), .CLK_DIV(A_CD), .HOLD_TICKS(A_H),
    .SEG_ACT_HIGH(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n),
    .dat(in_dat[0]), .dat_en(in_en[0]), .dot_en(in_dot[0]), .blank(in_blank[0]),
    .seg_rck(rck_a), .seg_sck(sck_a), .seg_din(din_a), .frame_done(fd_a)
  );

  seg595_scan_gen #(
    .NUM_DIGITS(B_N), .CLK_DIV(B_CD), .HOLD_TICKS(B_H),
    .SEG_ACT_HIGH(1'b0), .DIG_ACT_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n),
    .dat(in_dat[1][11:0]), .dat_en(in_en[1][2:0]), .dot_en(in_dot[1][2:0]),
    .blank(in_blank[1]),
    .seg_rck(rck_b), .seg_sck(sck_b), .seg_din(din_b), .frame_done(fd_b)
  );

  // per-instance parameters for the model
  function automatic int p_n(int d);   return (d == 0) ? A_N : B_N; endfunction
  function automatic int p_cd(int d);  return (d == 0) ? A_CD : B_CD; endfunction
  function automatic int p_h(int d);   return (d == 0) ? A_H : B_H; endfunction
  function automatic bit p_seg_hi(int d); return (d == 0); endfunction
  function automatic bit p_dig_lo(int d); return (d == 0); endfunction

  // counters and check helper
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // behavioural model
  function automatic logic [6:0] font7(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [15:0] model_word(int d, int idx);
    logic [3:0] code;
    logic [7:0] seg, sel;
    logic       on;
    code = 4'((in_dat[d] >> (4 * idx)) & 32'hF);
    on   = in_en[d][idx] && !in_blank[d];
    seg  = on ? {in_dot[d][idx], font7(code)} : 8'h00;
    sel  = on ? (8'h01 << idx) : 8'h00;
    if (!p_seg_hi(d)) seg = ~seg;
    if (p_dig_lo(d))  sel = ~sel;
    return {seg, sel};
  endfunction

  // scoreboard
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] lw_a[$];
  logic [15:0] lw_b[$];
  int          fd_log_a[$];
  int          fd_log_b[$];

  function automatic void push_exp(int d, logic [15:0] w);
    if (d == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
  endfunction

  function automatic logic [16:0] peek_exp(int d);
    if (d == 0) return (exp_q0.size() > 0) ? {1'b1, exp_q0[0]} : 17'h0;
    return (exp_q1.size() > 0) ? {1'b1, exp_q1[0]} : 17'h0;
  endfunction

  function automatic logic [16:0] pop_exp(int d);
    if (d == 0) return (exp_q0.size() > 0) ? {1'b1, exp_q0.pop_front()} : 17'h0;
    return (exp_q1.size() > 0) ? {1'b1, exp_q1.pop_front()} : 17'h0;
  endfunction

  // monitor / compare process
  logic        prev_sck [2], prev_rck [2], prev_din [2], prev_fd [2];
  logic [15:0] shreg [2];
  int          nbits [2], lat_n [2], last_sck_c [2], rck_rise_c [2], last_rck_c [2], fd_due [2];
  logic        s_rck, s_sck, s_din, s_fd, s_rn;
  logic [16:0] pk;

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_sck[d] = 0; prev_rck[d] = 0; prev_din[d] = 0; prev_fd[d] = 0;
      shreg[d] = '0; nbits[d] = 0; lat_n[d] = 0; last_sck_c[d] = 0;
      rck_rise_c[d] = 0; last_rck_c[d] = -1; fd_due[d] = -1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      s_rck = (d == 0) ? rck_a : rck_b;
      s_sck = (d == 0) ? sck_a : sck_b;
      s_din = (d == 0) ? din_a : din_b;
      s_fd  = (d == 0) ? fd_a  : fd_b;
      s_rn  = (d == 0) ? rst_a_n : rst_b_n;
      if (!s_rn) begin
        lat_n[d] = 0; nbits[d] = 0; last_rck_c[d] = -1; fd_due[d] = -1;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        chk($sformatf("frame_done[%0d]", d), 32'(s_fd), 32'(cyc == fd_due[d]));
        if (s_fd && !prev_fd[d]) begin
          if (d == 0) fd_log_a.push_back(cyc); else fd_log_b.push_back(cyc);
        end
        if (s_sck && !prev_sck[d]) begin
          // first bit of a frame: fix the frame's words from the inputs now
          if (nbits[d] == 0 && (lat_n[d] % p_n(d)) == 0)
            for (int i = 0; i < p_n(d); i++) push_exp(d, model_word(d, i));
          pk = peek_exp(d);
          if (nbits[d] > 0)
            chk($sformatf("sck_period[%0d]", d), 32'(cyc - last_sck_c[d]), 32'(2 * p_cd(d)));
          if (nbits[d] < 16) begin
            chk($sformatf("din_setup[%0d]", d), {31'h0, prev_din[d]}, {31'h0, pk[15 - nbits[d]]});
            chk($sformatf("din_bit[%0d]", d),   {31'h0, s_din},       {31'h0, pk[15 - nbits[d]]});
          end
          shreg[d]      = {shreg[d][14:0], s_din};
          nbits[d]      = nbits[d] + 1;
          last_sck_c[d] = cyc;
        end
        if (s_rck && !prev_rck[d]) begin
          chk($sformatf("bit_count[%0d]", d), 32'(nbits[d]), 32'd16);
          if (last_rck_c[d] >= 0)
            chk($sformatf("digit_period[%0d]", d), 32'(cyc - last_rck_c[d]),
                32'((35 + p_h(d)) * p_cd(d)));
          pk = pop_exp(d);
          chk($sformatf("latched_word[%0d]", d), {15'h0, 1'b1, shreg[d]}, {15'h0, pk});
          if (d == 0) lw_a.push_back(shreg[d]); else lw_b.push_back(shreg[d]);
          if ((lat_n[d] % p_n(d)) == p_n(d) - 1) fd_due[d] = cyc + (1 + p_h(d)) * p_cd(d);
          lat_n[d]      = lat_n[d] + 1;
          nbits[d]      = 0;
          rck_rise_c[d] = cyc;
          last_rck_c[d] = cyc;
        end
        if (!s_rck && prev_rck[d])
          chk($sformatf("rck_width[%0d]", d), 32'(cyc - rck_rise_c[d]), 32'(p_cd(d)));
      end
      prev_sck[d] = s_sck; prev_rck[d] = s_rck; prev_din[d] = s_din; prev_fd[d] = s_fd;
    end
  end

  // driver tasks
  task automatic wait_lat(input int d, input int n);
    int t;
    t = 0;
    while ((((d == 0) ? lw_a.size() : lw_b.size()) < n) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_lat dut %0d: got %0d latches, expected %0d", d,
               (d == 0) ? lw_a.size() : lw_b.size(), n);
    end
  endtask

  task automatic run_a();
    int t;
    wait_lat(0, 4);
    chk("a_digit0_word", 32'(lw_a[0]), 32'h3FFE);
    chk("a_digit1_word", 32'(lw_a[1]), 32'h06FD);
    in_dat[0] = 32'hFEDCBA98;                 // mid-frame change, during digit 4
    wait_lat(0, 12);
    chk("a_old_digit4", 32'(lw_a[4]), 32'h66EF);
    chk("a_old_digit7", 32'(lw_a[7]), 32'h077F);
    chk("a_new_digit0", 32'(lw_a[8]), 32'h7FFE);
    chk("a_new_digit3", 32'(lw_a[11]), 32'h7CF7);
    in_dat[0] = 32'h76543210;
    in_en[0]  = 8'hFE;
    in_dot[0] = 8'h02;
    wait_lat(0, 18);
    chk("a_off_digit0", 32'(lw_a[16]), 32'h00FF);
    chk("a_dot_digit1", 32'(lw_a[17]), 32'h86FD);
    chk("a_frame_period", (fd_log_a.size() >= 2) ? 32'(fd_log_a[1] - fd_log_a[0]) : 32'hFFFF_FFFF,
        32'd1120);
    // reset while SHIFT is at k=17 (ninth SCK rise of the digit)
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (nbits[0] != 9 && t < 1000);
    if (t >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL a_find_k17: got no ninth SCK rise, expected one within 1000 cycles");
    end
    #1 rst_a_n = 1'b0;
    #1 chk("a_async_reset_outs", {28'h0, rck_a, sck_a, din_a, fd_a}, 32'h0);
    repeat (3) @(negedge clk);
    #1 rst_a_n = 1'b1;
    wait_lat(0, 19);
    chk("a_restart_digit0", 32'(lw_a[18]), 32'h00FF);
  endtask

  task automatic run_b();
    wait_lat(1, 2);
    chk("b_digit0_word", 32'(lw_b[0]), 32'h8001);
    chk("b_digit1_word", 32'(lw_b[1]), 32'h8802);
    in_blank[1] = 1'b1;
    wait_lat(1, 5);
    chk("b_digit2_word", 32'(lw_b[2]), 32'h9204);
    chk("b_blank0", 32'(lw_b[3]), 32'hFF00);
    chk("b_blank1", 32'(lw_b[4]), 32'hFF00);
    in_blank[1] = 1'b0;
    in_en[1]    = 8'h05;
    in_dot[1]   = 8'h04;
    wait_lat(1, 9);
    chk("b_blank2", 32'(lw_b[5]), 32'hFF00);
    chk("b_digit0_again", 32'(lw_b[6]), 32'h8001);
    chk("b_off_digit1", 32'(lw_b[7]), 32'hFF00);
    chk("b_dot_digit2", 32'(lw_b[8]), 32'h1204);
    chk("b_frame_period", (fd_log_b.size() >= 2) ? 32'(fd_log_b[1] - fd_log_b[0]) : 32'hFFFF_FFFF,
        32'd333);
  endtask

  // main sequence and final report
  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    in_dat[0] = 32'h76543210; in_en[0] = 8'hFF; in_dot[0] = 8'h00; in_blank[0] = 1'b0;
    in_dat[1] = 32'h000005A8; in_en[1] = 8'h07; in_dot[1] = 8'h00; in_blank[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_reset_outs", {28'h0, rck_a, sck_a, din_a, fd_a}, 32'h0);
    chk("b_reset_outs", {28'h0, rck_b, sck_b, din_b, fd_b}, 32'h0);
    @(negedge clk);
    #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
